// File: rtl/vp_centroid.sv
// Object centroid tracker: sums mask-pixel coordinates over a frame, divides at frame end,
// publishes the centroid and draws a cross marker at it on the passing video.
module vp_centroid #(
    parameter int          H_SIZE       = 1280,
    parameter int          V_SIZE       = 720,
    parameter int          COORD_W      = 11,
    parameter int          SUM_W        = 32,
    parameter int          CNT_W        = 21,
    parameter int          MARKER_HALF  = 8,
    parameter logic [23:0] MARKER_COLOR = 24'hFF0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [23:0]        pixel_in,
    input  logic               de_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    output logic [23:0]        pixel_out,
    output logic               de_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic [COORD_W-1:0] x_c,
    output logic [COORD_W-1:0] y_c,
    output logic               c_found,
    output logic               c_valid
);

    localparam int                 BIT_W  = $clog2(SUM_W);
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_SIZE - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_SIZE - 1);
    localparam logic [COORD_W:0]   HALF_C = (COORD_W + 1)'(MARKER_HALF);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(SUM_W - 1);

    typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, DONE} state_e;

    // Video pipeline and position tracking
    logic [23:0]        pixel_q;
    logic               de_q, hs_q, vs_q;
    logic [COORD_W-1:0] x_q, y_q, x_d, y_d;

    // Accumulation and frame snapshot
    logic [SUM_W-1:0]   sum_x_q, sum_y_q, snap_sx_q, snap_sy_q;
    logic [CNT_W-1:0]   cnt_q, snap_cnt_q;
    logic               armed_q;

    // Divider FSM and results
    state_e             state_q;
    logic [SUM_W-1:0]   div_num_q;
    logic [CNT_W-1:0]   div_rem_q;
    logic [BIT_W-1:0]   bit_q;
    logic [COORD_W-1:0] quo_x_q, x_c_q, y_c_q;
    logic               c_found_q, c_valid_q;

    logic de_fall, vs_rise, frame_end;
    assign de_fall   = de_q & ~de_in;
    assign vs_rise   = v_sync_in & ~vs_q;
    // A partial frame seen after reset is never reported; the first vsync edge only arms.
    assign frame_end = vs_rise & armed_q;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise latches are inferred.
        x_d = x_q;
        y_d = y_q;
        if (vs_rise) begin
            x_d = '0;
            y_d = '0;
        end else if (de_in) begin
            x_d = (x_q == X_MAX) ? x_q : x_q + COORD_W'(1);
        end else if (de_fall) begin
            x_d = '0;
            y_d = (y_q == Y_MAX) ? y_q : y_q + COORD_W'(1);
        end
    end

    logic signed [COORD_W:0] dx, dy;
    logic        [COORD_W:0] adx, ady;
    logic                    hit;
    assign dx  = $signed({1'b0, x_q}) - $signed({1'b0, x_c_q});
    assign dy  = $signed({1'b0, y_q}) - $signed({1'b0, y_c_q});
    assign adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    assign ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    assign hit = c_found_q & de_in &
                 (((x_q == x_c_q) && (ady <= HALF_C)) || ((y_q == y_c_q) && (adx <= HALF_C)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            pixel_q <= hit ? MARKER_COLOR : pixel_in;
            de_q    <= de_in;
            hs_q    <= h_sync_in;
            vs_q    <= v_sync_in;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            cnt_q      <= '0;
            snap_sx_q  <= '0;
            snap_sy_q  <= '0;
            snap_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else if (vs_rise) begin
            snap_sx_q  <= sum_x_q;
            snap_sy_q  <= sum_y_q;
            snap_cnt_q <= cnt_q;
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
        end else if (de_in && pixel_in[0]) begin
            sum_x_q <= sum_x_q + SUM_W'(x_q);
            sum_y_q <= sum_y_q + SUM_W'(y_q);
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] rem_nx;
    logic [SUM_W-1:0] num_nx;
    logic             div_ge;
    assign rem_sh = {div_rem_q, div_num_q[SUM_W-1]};
    assign div_ge = rem_sh >= {1'b0, snap_cnt_q};
    assign rem_nx = div_ge ? (rem_sh[CNT_W-1:0] - snap_cnt_q) : rem_sh[CNT_W-1:0];
    assign num_nx = {div_num_q[SUM_W-2:0], div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_num_q <= '0;
            div_rem_q <= '0;
            bit_q     <= '0;
            quo_x_q   <= '0;
            x_c_q     <= '0;
            y_c_q     <= '0;
            c_found_q <= 1'b0;
            c_valid_q <= 1'b0;
        end else begin
            c_valid_q <= 1'b0;
            if (frame_end) begin
                state_q <= CHECK;
            end else begin
                case (state_q)
                    IDLE: state_q <= IDLE;
                    CHECK: begin
                        if (snap_cnt_q == '0) begin
                            state_q <= DONE;
                        end else begin
                            div_num_q <= snap_sx_q;
                            div_rem_q <= '0;
                            bit_q     <= '0;
                            state_q   <= DIV_X;
                        end
                    end
                    DIV_X: begin
                        if (bit_q == LAST_BIT) begin
                            quo_x_q   <= num_nx[COORD_W-1:0];
                            div_num_q <= snap_sy_q;
                            div_rem_q <= '0;
                            bit_q     <= '0;
                            state_q   <= DIV_Y;
                        end else begin
                            div_num_q <= num_nx;
                            div_rem_q <= rem_nx;
                            bit_q     <= bit_q + BIT_W'(1);
                        end
                    end
                    DIV_Y: begin
                        div_num_q <= num_nx;
                        div_rem_q <= rem_nx;
                        bit_q     <= bit_q + BIT_W'(1);
                        if (bit_q == LAST_BIT) state_q <= DONE;
                    end
                    DONE: begin
                        if (snap_cnt_q != '0) begin
                            x_c_q     <= quo_x_q;
                            y_c_q     <= div_num_q[COORD_W-1:0];
                            c_found_q <= 1'b1;
                        end else begin
                            c_found_q <= 1'b0;
                        end
                        c_valid_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pixel_out  = pixel_q;
    assign de_out     = de_q;
    assign h_sync_out = hs_q;
    assign v_sync_out = vs_q;
    assign x_c        = x_c_q;
    assign y_c        = y_c_q;
    assign c_found    = c_found_q;
    assign c_valid    = c_valid_q;

endmodule

// File: doc/vp_centroid.md
Name: vp_centroid

Overview:
- Downstream consumer of the thresholding stage in the video processing chain.
- Takes the binary mask video (0x000000 or 0xFFFFFF per pixel) and accumulates x/y coordinate sums and pixel count over each frame.
- At frame end, divides the sums by the count to obtain the object centroid.
- Overlays a cross marker at the last valid centroid onto the passing video, and exposes the coordinates on ports.

Parameters:
- H_SIZE, 1280, active pixels per line
- V_SIZE, 720, active lines per frame
- COORD_W, 11, width of x/y coordinates; must cover max(H_SIZE, V_SIZE)-1
- SUM_W, 32, width of the coordinate sum accumulators
- CNT_W, 21, width of the mask pixel counter; must hold H_SIZE*V_SIZE
- MARKER_HALF, 8, half-length in pixels of each cross arm
- MARKER_COLOR, 24'hFF0000, overlay colour

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- pixel_in  input  24  mask video; pixel is "set" when pixel_in[0]==1
- de_in  input  1  data enable
- h_sync_in  input  1  horizontal sync
- v_sync_in  input  1  vertical sync, active high
- pixel_out  output  24  video with marker overlay
- de_out  output  1  de_in delayed 1 cycle
- h_sync_out  output  1  h_sync_in delayed 1 cycle
- v_sync_out  output  1  v_sync_in delayed 1 cycle
- x_c  output  COORD_W  centroid x of last completed frame
- y_c  output  COORD_W  centroid y of last completed frame
- c_found  output  1  1 if last completed frame had count>0
- c_valid  output  1  one-cycle pulse when x_c/y_c/c_found update

Behaviour:
- Reset: all outputs 0; counters, accumulators and sync delay registers 0; FSM to IDLE.
- Datapath latency: exactly 1 cycle for pixel and all sync signals. The overlay decision uses the registered x/y of the same pixel.
- Position tracking:
  - x increments on each de_in=1 cycle.
  - x clears to 0 on the de_in falling edge, and y increments at that same edge.
  - x and y both clear on the v_sync_in rising edge.
  - x/y saturate at H_SIZE-1 / V_SIZE-1 if the input overruns the nominal size; no wrap.
- Accumulation: when de_in=1 and pixel_in[0]=1, sum_x+=x, sum_y+=y, cnt+=1.
- Frame end (v_sync_in rising edge):
  - sum_x, sum_y and cnt are snapshotted into divider registers.
  - The accumulators clear in the same cycle.
  - A pixel that coincides with that edge is not counted.
- FSM states: IDLE, CHECK, DIV_X, DIV_Y, DONE.
  - IDLE -> CHECK on frame end.
  - CHECK: if cnt==0, go to DONE with c_found=0 and x_c/y_c held at their previous values; otherwise go to DIV_X.
  - DIV_X: restoring divider, one quotient bit per cycle, SUM_W cycles, computes sum_x/cnt. Then go to DIV_Y.
  - DIV_Y: same divider for sum_y/cnt. Then go to DONE.
  - DONE: latch quotients (truncated, low COORD_W bits) into x_c/y_c, set c_found=1 (or 0 per CHECK), pulse c_valid for one cycle, return to IDLE.
- Total divide time is 2*SUM_W+3 cycles, which must fit in vertical blanking.
- Frame end while the FSM is not IDLE: abort the current division, take the new snapshot, and restart at CHECK. No c_valid is emitted for the aborted frame.
- Overlay: when c_found=1 and de_in=1, pixel_out=MARKER_COLOR if either:
  - x==x_c and |y-y_c|<=MARKER_HALF, or
  - y==y_c and |x-x_c|<=MARKER_HALF.
  - Otherwise pixel_out=pixel_in.
  - Differences are computed signed; the cross is clipped at image borders.
- When de_in=0, pixel_out=pixel_in (passthrough of blanking data).
- Asynchronous reset mid-frame: all state is dropped, and the first frame after reset starts only at the next v_sync_in rising edge.

Test Plan:
- Frame of H_SIZE=16, V_SIZE=8 with a single set pixel at (5,3) -> after frame end, within 2*SUM_W+3 cycles: c_valid pulses once, x_c=5, y_c=3, c_found=1.
- Set pixels at (2,2),(3,2),(2,3),(3,3) -> x_c=2, y_c=2 (truncation of 2.5); next frame shows the cross centred at (2,2) in MARKER_COLOR and all other pixels passed through unchanged.
- All-zero mask frame after a valid frame -> c_valid pulses, c_found=0, x_c/y_c unchanged, and no marker drawn on the following frame.
- Second v_sync_in rising edge 10 cycles after the first (mid-division) -> no c_valid for the first frame; the result matches the second snapshot.
- Full frame of set pixels on a 16x8 image -> x_c=7, y_c=3; cross clipped at the borders without wrap artefacts.
- rst_n asserted mid-line -> all outputs 0 immediately; after release, sync outputs follow the inputs with 1-cycle latency and no c_valid occurs before a complete frame.
